// File: rtl/operand_port_pkg.sv
// Shared types and widths for the operand/result transfer port.
package operand_port_pkg;

  localparam int ADDR_W = 9;
  localparam int OPND_W = 8;
  localparam int RES_W  = 16;

  typedef logic [1:0] ch_t;
  localparam ch_t CH_A = 2'd0;
  localparam ch_t CH_B = 2'd1;
  localparam ch_t CH_C = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    RD_CAPT,
    WR,
    DONE
  } state_e;

endpackage

// File: rtl/operand_port_if.sv
// Controller/memory-facing signal bundle of the operand port.
interface operand_port_if;
  import operand_port_pkg::*;

  logic              en_a;
  logic              en_b;
  logic              en_c;
  logic [ADDR_W-1:0] endereco;
  logic [RES_W-1:0]  result_in;
  logic [ADDR_W-1:0] rom_addr;
  logic [OPND_W-1:0] rom_data;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [RES_W-1:0]  ram_wdata;
  logic [OPND_W-1:0] a_out;
  logic [OPND_W-1:0] b_out;
  logic              fim_a;
  logic              fim_b;
  logic              fim_c;
  logic [7:0]        n_results;

  modport slave (
    input  en_a, en_b, en_c, endereco, result_in, rom_data,
    output rom_addr, ram_we, ram_addr, ram_wdata, a_out, b_out,
           fim_a, fim_b, fim_c, n_results
  );

  modport master (
    output en_a, en_b, en_c, endereco, result_in, rom_data,
    input  rom_addr, ram_we, ram_addr, ram_wdata, a_out, b_out,
           fim_a, fim_b, fim_c, n_results
  );

endinterface

// File: rtl/hs_arm.sv
// Per-channel arm flag: a channel is served once per enable assertion and
// re-arms whenever its enable is seen low.
module hs_arm (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic armed,
  output logic req
);

  logic armed_d, armed_q;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    armed_d = armed_q;
    if (!en)      armed_d = 1'b1;  // a low enable wins over a same-cycle done
    else if (clr) armed_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed_q <= 1'b1;
    else        armed_q <= armed_d;
  end

  assign armed = armed_q;
  assign req   = en & armed_q;

endmodule

// File: rtl/operand_port.sv
// Responder for the controller's enable/done handshake: reads operands A/B
// from the synchronous ROM and writes result C to the RAM, one done pulse each.
module operand_port
  import operand_port_pkg::*;
#(
  parameter int ROM_LAT = 1
) (
  input logic           clk,
  input logic           rst_n,
  operand_port_if.slave bus
);

  localparam logic [1:0] WAIT_INIT = (ROM_LAT > 1) ? 2'(ROM_LAT - 2) : 2'd0;

  state_e            state_d, state_q;
  ch_t               ch_d, ch_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [RES_W-1:0]  res_d, res_q;
  logic [1:0]        wait_d, wait_q;

  logic [ADDR_W-1:0] rom_addr_d, rom_addr_q;
  logic              ram_we_d, ram_we_q;
  logic [ADDR_W-1:0] ram_addr_d, ram_addr_q;
  logic [RES_W-1:0]  ram_wdata_d, ram_wdata_q;
  logic              cap_d, cap_q;
  logic [OPND_W-1:0] a_d, a_q, b_d, b_q;
  logic              fim_a_d, fim_a_q, fim_b_d, fim_b_q, fim_c_d, fim_c_q;
  logic [7:0]        n_d, n_q;

  logic req_a, req_b, req_c;
  logic armed_a, armed_b, armed_c;
  logic done_a, done_b, done_c;

  assign done_a = (state_q == DONE) && (ch_q == CH_A);
  assign done_b = (state_q == DONE) && (ch_q == CH_B);
  assign done_c = (state_q == DONE) && (ch_q == CH_C);

  hs_arm u_arm_a (.clk, .rst_n, .en(bus.en_a), .clr(done_a & armed_a), .armed(armed_a), .req(req_a));
  hs_arm u_arm_b (.clk, .rst_n, .en(bus.en_b), .clr(done_b & armed_b), .armed(armed_b), .req(req_b));
  hs_arm u_arm_c (.clk, .rst_n, .en(bus.en_c), .clr(done_c & armed_c), .armed(armed_c), .req(req_c));

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    addr_d  = addr_q;
    res_d   = res_q;
    wait_d  = wait_q;
    unique case (state_q)
      IDLE: begin
        if (req_a) begin
          ch_d    = CH_A;
          addr_d  = bus.endereco;
          state_d = RD_ISSUE;
        end else if (req_b) begin
          ch_d    = CH_B;
          addr_d  = bus.endereco;
          state_d = RD_ISSUE;
        end else if (req_c) begin
          ch_d    = CH_C;
          addr_d  = bus.endereco;
          res_d   = bus.result_in;
          state_d = WR;
        end
      end
      RD_ISSUE: begin
        if (ROM_LAT > 1) begin
          wait_d  = WAIT_INIT;
          state_d = RD_WAIT;
        end else begin
          state_d = RD_CAPT;
        end
      end
      RD_WAIT: begin
        if (wait_q == 2'd0) state_d = RD_CAPT;
        else                wait_d  = wait_q - 2'd1;
      end
      RD_CAPT: state_d = DONE;
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered one stage behind the state that produces them, so
  // the capture lands on the edge after RD_CAPT, once ROM data is settled.
  always_comb begin
    rom_addr_d  = (state_q == RD_ISSUE) ? addr_q : rom_addr_q;
    ram_we_d    = (state_q == WR);
    ram_addr_d  = (state_q == WR) ? addr_q : ram_addr_q;
    ram_wdata_d = (state_q == WR) ? res_q  : ram_wdata_q;
    cap_d       = (state_q == RD_CAPT);
    a_d         = (cap_q && ch_q == CH_A) ? bus.rom_data : a_q;
    b_d         = (cap_q && ch_q == CH_B) ? bus.rom_data : b_q;
    fim_a_d     = done_a;
    fim_b_d     = done_b;
    fim_c_d     = done_c;
    n_d         = done_c ? n_q + 8'd1 : n_q;
  end

  // NOTE: these are plain registers, not memories, so all of them take the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ch_q        <= CH_A;
      addr_q      <= '0;
      res_q       <= '0;
      wait_q      <= '0;
      rom_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      cap_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      fim_a_q     <= 1'b0;
      fim_b_q     <= 1'b0;
      fim_c_q     <= 1'b0;
      n_q         <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      addr_q      <= addr_d;
      res_q       <= res_d;
      wait_q      <= wait_d;
      rom_addr_q  <= rom_addr_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      cap_q       <= cap_d;
      a_q         <= a_d;
      b_q         <= b_d;
      fim_a_q     <= fim_a_d;
      fim_b_q     <= fim_b_d;
      fim_c_q     <= fim_c_d;
      n_q         <= n_d;
    end
  end

  assign bus.rom_addr  = rom_addr_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.a_out     = a_q;
  assign bus.b_out     = b_q;
  assign bus.fim_a     = fim_a_q;
  assign bus.fim_b     = fim_b_q;
  assign bus.fim_c     = fim_c_q;
  assign bus.n_results = n_q;

endmodule

// File: tb/tb_operand_port.sv
// Bench for operand_port: ROM/RAM models, pulse monitors and a transaction
// model that predicts done cycles, operand values and the result count.
module tb_operand_port;
  import operand_port_pkg::*;

  localparam int LAT1 = 1;
  localparam int LAT3 = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  operand_port_if if1 ();
  operand_port_if if3 ();

  operand_port #(.ROM_LAT(LAT1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  operand_port #(.ROM_LAT(LAT3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  logic [7:0]  rom_mem [512];
  logic [15:0] ram_mem [512];
  logic [7:0]  p1;
  logic [7:0]  p3 [3];

  // ROM: data appears ROM_LAT edges after the address; RAM: written on ram_we.
  always @(posedge clk) begin
    p1    <= rom_mem[if1.rom_addr];
    p3[0] <= rom_mem[if3.rom_addr];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
    if (if1.ram_we) ram_mem[if1.ram_addr] <= if1.ram_wdata;
  end
  assign if1.rom_data = p1;
  assign if3.rom_data = p3[2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int fim_n [3];
  int fim_at [3];
  int we_n = 0, we_at = 0, fim3_n = 0, fim3_at = 0;

  always @(negedge clk) begin
    if (if1.fim_a)  begin fim_n[0]++; fim_at[0] = cyc; end
    if (if1.fim_b)  begin fim_n[1]++; fim_at[1] = cyc; end
    if (if1.fim_c)  begin fim_n[2]++; fim_at[2] = cyc; end
    if (if1.ram_we) begin we_n++;     we_at     = cyc; end
    if (if3.fim_b)  begin fim3_n++;   fim3_at   = cyc; end
  end

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] exp_a = '0, exp_b = '0, exp_n = '0;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_en(input int ch, input logic v);
    case (ch)
      0:       if1.en_a = v;
      1:       if1.en_b = v;
      default: if1.en_c = v;
    endcase
  endtask

  task automatic check_idle_outputs(input string tag);
    n_chk++;
    if ({if1.rom_addr, if1.ram_we, if1.ram_addr, if1.ram_wdata, if1.a_out, if1.b_out,
         if1.fim_a, if1.fim_b, if1.fim_c, if1.n_results} !== '0) begin
      $display("FAIL %s outputs: got rom_addr=%0h ram_we=%0b a=%0h b=%0h fim=%0b%0b%0b n=%0d, want all 0",
               tag, if1.rom_addr, if1.ram_we, if1.a_out, if1.b_out,
               if1.fim_a, if1.fim_b, if1.fim_c, if1.n_results);
    end else n_pass++;
    n_chk++;
    if ({dut1.u_arm_a.armed, dut1.u_arm_b.armed, dut1.u_arm_c.armed} !== 3'b111 ||
        dut1.state_q !== IDLE) begin
      $display("FAIL %s armed/state: got armed=%0b%0b%0b state=%0d, want 111 IDLE", tag,
               dut1.u_arm_a.armed, dut1.u_arm_b.armed, dut1.u_arm_c.armed, dut1.state_q);
    end else n_pass++;
  endtask

  // One single-channel transfer on dut1; address/result are changed right after accept.
  task automatic run_txn(input int ch, input logic [8:0] addr, input logic [15:0] res,
                         input logic [8:0] s_addr, input logic [15:0] s_res,
                         input int hold, input string tag);
    int acc, f0, w0, lat;
    bit got;
    f0 = fim_n[ch];
    w0 = we_n;
    if1.endereco  = addr;
    if1.result_in = res;
    set_en(ch, 1'b1);
    acc = cyc + 1;
    tick();
    if1.endereco  = s_addr;
    if1.result_in = s_res;
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      tick();
      if (i == 0 && ch != 2) begin
        n_chk++;
        if (if1.rom_addr !== addr)
          $display("FAIL %s rom_addr: got %0h want %0h", tag, if1.rom_addr, addr);
        else n_pass++;
      end
      if (fim_n[ch] != f0) got = 1'b1;
    end
    n_chk++;
    if (!got) $display("FAIL %s timeout: got no fim on channel %0d, want one", tag, ch);
    else n_pass++;
    if (got) begin
      lat = (ch == 2) ? 2 : LAT1 + 2;
      if (ch == 0) exp_a = rom_mem[addr];
      if (ch == 1) exp_b = rom_mem[addr];
      if (ch == 2) exp_n = exp_n + 8'd1;
      n_chk++;
      if (fim_at[ch] != acc + lat)
        $display("FAIL %s fim_cycle: got T+%0d want T+%0d", tag, fim_at[ch] - acc, lat);
      else n_pass++;
      n_chk++;
      if (if1.a_out !== exp_a || if1.b_out !== exp_b)
        $display("FAIL %s operands: got a=%0h b=%0h want a=%0h b=%0h", tag,
                 if1.a_out, if1.b_out, exp_a, exp_b);
      else n_pass++;
      n_chk++;
      if (if1.n_results !== exp_n)
        $display("FAIL %s n_results: got %0d want %0d", tag, if1.n_results, exp_n);
      else n_pass++;
      if (ch == 2) begin
        n_chk++;
        if (ram_mem[addr] !== res || we_n != w0 + 1 || we_at != acc + 1)
          $display("FAIL %s ram_write: got data=%0h pulses=%0d at T+%0d want data=%0h pulses=1 at T+1",
                   tag, ram_mem[addr], we_n - w0, we_at - acc, res);
        else n_pass++;
      end
    end
    repeat (hold) tick();
    set_en(ch, 1'b0);
    tick();
    n_chk++;
    if (fim_n[ch] != f0 + 1)
      $display("FAIL %s fim_count: got %0d pulses want 1", tag, fim_n[ch] - f0);
    else n_pass++;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read_a();
    run_txn(0, 9'd5, 16'h0, 9'd300, 16'h0, 8, "read_a");
  endtask

  task automatic test_simultaneous();
    int acc, fa0, fc0;
    bit got;
    fa0 = fim_n[0];
    fc0 = fim_n[2];
    if1.endereco  = 9'd9;
    if1.result_in = 16'hBEEF;
    if1.en_a = 1'b1;
    if1.en_c = 1'b1;
    acc = cyc + 1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (fim_n[2] != fc0) got = 1'b1;
    end
    n_chk++;
    if (!got) $display("FAIL simul timeout: got no fim_c, want one");
    else n_pass++;
    exp_a = rom_mem[9];
    exp_n = exp_n + 8'd1;
    n_chk++;
    if (fim_at[0] != acc + LAT1 + 2 || fim_at[2] != acc + LAT1 + 5)
      $display("FAIL simul order: got fim_a T+%0d fim_c T+%0d want T+%0d T+%0d",
               fim_at[0] - acc, fim_at[2] - acc, LAT1 + 2, LAT1 + 5);
    else n_pass++;
    n_chk++;
    if (ram_mem[9] !== 16'hBEEF || we_at != acc + LAT1 + 4 || if1.n_results !== exp_n ||
        if1.a_out !== exp_a)
      $display("FAIL simul data: got ram=%0h we T+%0d n=%0d a=%0h want %0h T+%0d %0d %0h",
               ram_mem[9], we_at - acc, if1.n_results, if1.a_out,
               16'hBEEF, LAT1 + 4, exp_n, exp_a);
    else n_pass++;
    repeat (4) tick();
    if1.en_a = 1'b0;
    if1.en_c = 1'b0;
    tick();
    n_chk++;
    if (fim_n[0] != fa0 + 1 || fim_n[2] != fc0 + 1)
      $display("FAIL simul counts: got fim_a=%0d fim_c=%0d want 1 1", fim_n[0] - fa0, fim_n[2] - fc0);
    else n_pass++;
  endtask

  task automatic test_write_hold();
    run_txn(2, 9'd7, 16'h1234, 9'd8, 16'hFFFF, 4, "write_hold");
  endtask

  task automatic test_rom_lat3();
    int acc, f0;
    bit got;
    f0 = fim3_n;
    if3.endereco = 9'd2;
    if3.en_b = 1'b1;
    acc = cyc + 1;
    tick();
    if3.endereco = 9'd100;
    got = 1'b0;
    for (int i = 0; i < 15 && !got; i++) begin
      tick();
      if (i == 0) begin
        n_chk++;
        if (if3.rom_addr !== 9'd2) $display("FAIL lat3 rom_addr: got %0h want 2", if3.rom_addr);
        else n_pass++;
      end
      if (fim3_n != f0) got = 1'b1;
    end
    n_chk++;
    if (!got || fim3_at != acc + LAT3 + 2 || if3.b_out !== rom_mem[2])
      $display("FAIL lat3 read: got fim %0b at T+%0d b=%0h want T+%0d b=%0h",
               got, fim3_at - acc, if3.b_out, LAT3 + 2, rom_mem[2]);
    else n_pass++;
    repeat (5) tick();
    if3.en_b = 1'b0;
    tick();
    n_chk++;
    if (fim3_n != f0 + 1) $display("FAIL lat3 fim_count: got %0d want 1", fim3_n - f0);
    else n_pass++;
  endtask

  task automatic test_reset_mid_write();
    int w0, f0;
    w0 = we_n;
    f0 = fim_n[2];
    if1.endereco  = 9'd3;
    if1.result_in = 16'h5555;
    if1.en_c = 1'b1;
    tick();                    // dut1 now in WR
    rst_n = 1'b0;
    tick();
    check_idle_outputs("rst_mid_wr");
    tick();
    n_chk++;
    if (we_n != w0 || fim_n[2] != f0)
      $display("FAIL rst_mid_wr pulses: got ram_we=%0d fim_c=%0d want 0 0", we_n - w0, fim_n[2] - f0);
    else n_pass++;
    exp_a = '0;
    exp_b = '0;
    exp_n = '0;
    rst_n = 1'b1;
    if1.en_c = 1'b0;
    // en_c is reasserted through run_txn and held long after its done
    run_txn(2, 9'd3, 16'h5555, 9'd3, 16'h5555, 10, "after_rst");
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++) begin
      run_txn(int'($urandom_range(0, 2)), 9'($urandom), 16'($urandom),
              9'($urandom), 16'($urandom), int'($urandom_range(0, 3)), "random");
    end
  endtask

  task automatic test_wrap();
    logic [7:0] n0;
    run_txn(0, 9'd5, 16'h0, 9'd1, 16'h0, 0, "wrap_pre_a");
    run_txn(1, 9'd2, 16'h0, 9'd1, 16'h0, 0, "wrap_pre_b");
    n0 = if1.n_results;
    for (int k = 0; k < 256; k++) begin
      run_txn(2, 9'($urandom), 16'($urandom), 9'($urandom), 16'($urandom), 0, "wrap");
    end
    n_chk++;
    if (if1.n_results !== n0 || if1.a_out !== rom_mem[5] || if1.b_out !== rom_mem[2])
      $display("FAIL wrap final: got n=%0d a=%0h b=%0h want n=%0d a=%0h b=%0h",
               if1.n_results, if1.a_out, if1.b_out, n0, rom_mem[5], rom_mem[2]);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) rom_mem[i] = 8'($urandom);
    rom_mem[5] = 8'h2A;
    rom_mem[2] = 8'h81;
    fim_n  = '{0, 0, 0};
    fim_at = '{0, 0, 0};
    {if1.en_a, if1.en_b, if1.en_c} = 3'b000;
    {if3.en_a, if3.en_b, if3.en_c} = 3'b000;
    if1.endereco = '0;  if1.result_in = '0;
    if3.endereco = '0;  if3.result_in = '0;

    test_reset();
    test_read_a();
    test_simultaneous();
    test_write_hold();
    test_rom_lat3();
    test_reset_mid_write();
    test_random();
    test_wrap();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
